enemy_wave: RTL

Multi-slot enemy generator and mover for the barrage game. It manages `N_ENEMY` independent enemy slots. Each slot spawns at the right edge at a random height, steps left on a divided movement tick, and retires when it leaves the screen or is hit. The block sits between the random-number source and collision unit on one side and the renderer and score logic on the other. It provides per-slot positions, active flags, escape pulses and a saturating kill counter.

---
 rtl/enemy_wave.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/enemy_wave.sv
// Multi-slot enemy generator and mover for the barrage game.
// Each slot spawns at the right edge at a random height, steps left on a
// divided movement tick, and retires when it leaves the screen or is hit.
module enemy_wave #(
  parameter int N_ENEMY   = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int STEP      = 7,
  parameter int X_SPAWN   = 1180,
  parameter int X_EXIT    = 30,
  parameter int Y_RESET   = 350,
  parameter int Y_MAX     = 700,
  parameter int SPAWN_GAP = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pause,
  input  logic [N_ENEMY-1:0]     hit,
  input  logic [9:0]             randint,
  output logic [12*N_ENEMY-1:0]  enemy_x,
  output logic [12*N_ENEMY-1:0]  enemy_y,
  output logic [N_ENEMY-1:0]     active,
  output logic [N_ENEMY-1:0]     escape,
  output logic [15:0]            kill_count
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int IDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(SPAWN_GAP - 1);
  localparam logic [11:0]      X_SPAWN_C = 12'(X_SPAWN);
  localparam logic [11:0]      X_EXIT_C  = 12'(X_EXIT);
  localparam logic [11:0]      STEP_C    = 12'(STEP);
  localparam logic [11:0]      Y_RESET_C = 12'(Y_RESET);
  localparam logic [11:0]      Y_MAX_C   = 12'(Y_MAX);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slotState_e;

  logic [CNT_W-1:0]   tickCnt_q, tickCnt_d;
  logic               tick;
  logic [GAP_W-1:0]   spawnTimer_q, spawnTimer_d;
  logic               spawnEn;
  logic               anyIdle;
  logic [IDX_W-1:0]   spawnIdx;
  logic [11:0]        spawnY;
  logic [11:0]        randExt;

  slotState_e         state_q [N_ENEMY];
  slotState_e         state_d [N_ENEMY];
  logic [11:0]        xPos_q  [N_ENEMY];
  logic [11:0]        xPos_d  [N_ENEMY];
  logic [11:0]        yPos_q  [N_ENEMY];
  logic [11:0]        yPos_d  [N_ENEMY];
  logic [N_ENEMY-1:0] escape_q, escape_d;
  logic [15:0]        killCount_q, killCount_d;
  logic [4:0]         hitCount;
  logic [16:0]        killSum;

  // Movement tick divider: counter freezes while paused, tick marks the wrap cycle
  always_comb begin
    tickCnt_d = tickCnt_q;
    tick      = 1'b0;
    if (!pause) begin
      if (tickCnt_q == CNT_LAST) begin
        tick      = 1'b1;
        tickCnt_d = '0;
      end else begin
        tickCnt_d = tickCnt_q + CNT_W'(1);
      end
    end
  end

  // Spawn pacing: pick the lowest idle slot (pre-edge state) once the gap timer is full
  always_comb begin
    anyIdle      = 1'b0;
    spawnIdx     = '0;
    spawnEn      = 1'b0;
    spawnTimer_d = spawnTimer_q;
    randExt      = {2'b00, randint};
    spawnY       = (randExt <= Y_MAX_C) ? randExt : Y_MAX_C;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (state_q[i] == IDLE) begin
        anyIdle  = 1'b1;
        spawnIdx = IDX_W'(i);
      end
    end
    if (tick) begin
      if (spawnTimer_q == GAP_LAST) begin
        if (anyIdle) begin
          spawnEn      = 1'b1;
          spawnTimer_d = '0;
        end
      end else begin
        spawnTimer_d = spawnTimer_q + GAP_W'(1);
      end
    end
  end

  // Per-slot next state: hit beats escape beats move; idle slots only wake by spawning
  always_comb begin
    hitCount = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      state_d[i]  = state_q[i];
      xPos_d[i]   = xPos_q[i];
      yPos_d[i]   = yPos_q[i];
      escape_d[i] = 1'b0;
      if (state_q[i] == ACTIVE) begin
        if (hit[i]) begin
          state_d[i] = IDLE;
          xPos_d[i]  = X_SPAWN_C;
          hitCount   = hitCount + 5'd1;
        end else if (tick) begin
          if (xPos_q[i] <= X_EXIT_C) begin
            state_d[i]  = IDLE;
            xPos_d[i]   = X_SPAWN_C;
            escape_d[i] = 1'b1;
          end else begin
            xPos_d[i] = xPos_q[i] - STEP_C;
          end
        end
      end else if (spawnEn && (spawnIdx == IDX_W'(i))) begin
        state_d[i] = ACTIVE;
        xPos_d[i]  = X_SPAWN_C;
        yPos_d[i]  = spawnY;
      end
    end
    killSum     = {1'b0, killCount_q} + 17'(hitCount);
    killCount_d = killSum[16] ? 16'hFFFF : killSum[15:0];
  end

  // State registers with synchronous reset that returns every slot to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt_q    <= '0;
      spawnTimer_q <= '0;
      escape_q     <= '0;
      killCount_q  <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= IDLE;
        xPos_q[i]  <= X_SPAWN_C;
        yPos_q[i]  <= Y_RESET_C;
      end
    end else begin
      tickCnt_q    <= tickCnt_d;
      spawnTimer_q <= spawnTimer_d;
      escape_q     <= escape_d;
      killCount_q  <= killCount_d;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        xPos_q[i]  <= xPos_d[i];
        yPos_q[i]  <= yPos_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_ENEMY; g++) begin : g_pack
    assign enemy_x[12*g +: 12] = xPos_q[g];
    assign enemy_y[12*g +: 12] = yPos_q[g];
    assign active[g]           = (state_q[g] == ACTIVE);
  end

  assign escape     = escape_q;
  assign kill_count = killCount_q;

endmodule
